cache_responder: RTL and testbench

CACHE_RESPONDER -- requirements
Module: cache_responder

---
 rtl/cache_responder.sv | 117 +++++++++++
 tb/tb_cache_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cache_responder.sv
// Direct-mapped, write-through, no-write-allocate one-word-per-line cache front end.
// Loads that hit finish with no stall. Misses and stores go to backing memory, which a watchdog guards.
module cache_responder #(
    parameter int LINES       = 16,
    parameter int MEM_LAT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] address,
    input  logic [31:0] data,
    input  logic        r_en,
    input  logic        w_en,
    output logic        stall,
    output logic [31:0] saida_cache,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_err
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 12 - IDX_W;
    localparam int WD_W  = $clog2(MEM_LAT_MAX + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_LAT_MAX - 1);

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM} state_t;

    state_t           state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      word_mem [LINES];
    logic [WD_W-1:0]  wd_cnt;

    logic [IDX_W-1:0] cpu_idx, fill_idx;
    logic [TAG_W-1:0] cpu_tag, fill_tag;
    logic             hit, fill_we, store_we;

    assign cpu_idx  = address[IDX_W-1:0];
    assign cpu_tag  = address[11:IDX_W];
    // A fill always targets the address latched when the miss was taken.
    assign fill_idx = mem_addr[IDX_W-1:0];
    assign fill_tag = mem_addr[11:IDX_W];
    assign hit      = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign fill_we  = !reset && (state == RD_MISS) && mem_ready;
    assign store_we = !reset && (state == IDLE) && w_en && hit;

    // Tag and data arrays are left out of reset. The valid bits alone decide whether a line is live.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            word_mem[fill_idx] <= mem_rdata;
        end else if (store_we) begin
            word_mem[cpu_idx] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            stall       <= 1'b0;
            saida_cache <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_err     <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_en) begin
                        stall     <= 1'b1;
                        mem_addr  <= address;
                        mem_wdata <= data;
                        mem_wr    <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= WR_MEM;
                    end else if (r_en) begin
                        if (hit) begin
                            saida_cache <= word_mem[cpu_idx];
                        end else begin
                            stall    <= 1'b1;
                            mem_addr <= address;
                            mem_rd   <= 1'b1;
                            wd_cnt   <= '0;
                            state    <= RD_MISS;
                        end
                    end
                end
                RD_MISS, WR_MEM: begin
                    if (mem_ready) begin
                        if (state == RD_MISS) begin
                            valid[fill_idx] <= 1'b1;
                            saida_cache     <= mem_rdata;
                        end
                        stall  <= 1'b0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        mem_err <= 1'b1;
                        stall   <= 1'b0;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_responder.sv
// Directed bench for cache_responder. Expected load data and memory writes are queued when the stimulus is driven.
// They are popped and compared when the DUT completes the load or raises the write strobe.
module tb_cache_responder;
    localparam int LINES = 16;
    localparam int LAT   = 16;

    logic        clk = 1'b0;
    logic        reset, r_en, w_en, mem_ready;
    logic [11:0] address;
    logic [31:0] data, mem_rdata;
    logic        stall, mem_rd, mem_wr, mem_err;
    logic [31:0] saida_cache, mem_wdata;
    logic [11:0] mem_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q[$];
    logic [43:0] wr_q[$];

    cache_responder #(.LINES(LINES), .MEM_LAT_MAX(LAT)) dut (
        .clk(clk), .reset(reset), .address(address), .data(data),
        .r_en(r_en), .w_en(w_en), .stall(stall), .saida_cache(saida_cache),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_read(input logic [11:0] a);
        address = a; r_en = 1'b1;
        tick();
        r_en = 1'b0;
    endtask

    task automatic issue_write(input logic [11:0] a, input logic [31:0] d, input logic also_rd);
        address = a; data = d; w_en = 1'b1; r_en = also_rd;
        wr_q.push_back({a, d});
        tick();
        w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        mem_rdata = rd; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    endtask

    task automatic check_load(input string tag);
        logic [31:0] e;
        if (rd_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 44'd1, 44'd0);
        end else begin
            e = rd_q.pop_front();
            chk(tag, {12'h0, saida_cache}, {12'h0, e});
        end
    endtask

    task automatic check_store(input string tag);
        logic [43:0] e;
        if (wr_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 44'd1, 44'd0);
        end else begin
            e = wr_q.pop_front();
            chk(tag, {mem_addr, mem_wdata}, e);
        end
    endtask

    initial begin
        int n;
        logic [31:0] held;
        reset = 1'b1; r_en = 1'b0; w_en = 1'b0; mem_ready = 1'b0;
        address = '0; data = '0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_outs", {stall, mem_rd, mem_wr, mem_err, mem_addr, saida_cache}, 44'h0);

        // Cold read 0x005: memory answers after 3 cycles, so stall is high for 4.
        rd_q.push_back(32'hDEADBEEF);
        issue_read(12'h005);
        chk("cold_mem_rd", {mem_rd, mem_addr}, {1'b1, 12'h005});
        n = int'(stall);
        repeat (3) begin tick(); n += int'(stall); end
        chk("cold_rd_held", mem_rd, 1);
        respond(32'hDEADBEEF);
        chk("cold_stall_cycles", n, 4);
        chk("cold_stall_low", {stall, mem_rd}, 0);
        check_load("cold_data");

        // A repeat read hits: no stall and no memory read.
        rd_q.push_back(32'hDEADBEEF);
        saida_cache_clear: begin end
        issue_read(12'h005);
        chk("hit_no_stall", {stall, mem_rd}, 0);
        check_load("hit_data");

        // A store hit writes through. saida_cache keeps its last value, then a reload returns the new word.
        held = saida_cache;
        issue_write(12'h005, 32'h12345678, 1'b0);
        chk("st_strobe", {stall, mem_wr, mem_rd}, 3'b110);
        check_store("st_mem");
        tick();
        respond(32'h0);
        chk("st_done", {stall, mem_wr}, 0);
        chk("st_saida_hold", saida_cache, held);
        rd_q.push_back(32'h12345678);
        issue_read(12'h005);
        chk("st_hit_no_rd", {stall, mem_rd}, 0);
        check_load("st_hit_data");

        // 0x015 shares index 5 with 0x005. Filling 0x015 evicts 0x005.
        rd_q.push_back(32'hCAFEF00D);
        issue_read(12'h015);
        chk("conf_miss", {mem_rd, mem_addr}, {1'b1, 12'h015});
        tick();
        respond(32'hCAFEF00D);
        check_load("conf_fill");
        rd_q.push_back(32'h12345678);
        issue_read(12'h005);
        chk("conf_remiss", {mem_rd, mem_addr}, {1'b1, 12'h005});
        respond(32'h12345678);
        check_load("conf_refill");

        // With both enables high, only the write path runs. A read pulse during WR_MEM is ignored.
        held = saida_cache;
        issue_write(12'h020, 32'hA5A5_0F0F, 1'b1);
        chk("both_wr_only", {mem_wr, mem_rd}, 2'b10);
        check_store("both_mem");
        issue_read(12'h015);
        chk("busy_ignore", {stall, mem_wr, mem_rd, mem_addr}, {3'b110, 12'h020});
        chk("busy_saida", saida_cache, held);
        respond(32'h0);
        chk("both_done", stall, 0);
        // A store miss does not allocate, so 0x020 still misses.
        rd_q.push_back(32'h0000_2020);
        issue_read(12'h020);
        chk("noalloc_miss", mem_rd, 1);
        respond(32'h0000_2020);
        check_load("noalloc_fill");

        // mem_ready while IDLE is ignored.
        held = saida_cache;
        respond(32'hFFFF_FFFF);
        chk("idle_ready", {stall, mem_rd, mem_wr}, 0);
        chk("idle_ready_saida", saida_cache, held);

        // Watchdog: mem_ready never arrives.
        issue_read(12'h033);
        repeat (3) tick();
        chk("wd_not_yet", {mem_err, stall}, 2'b01);
        n = 3;
        while (!mem_err && n < LAT + 5) begin tick(); n++; end
        chk("wd_err", mem_err, 1);
        chk("wd_not_early", (n >= LAT - 1), 1);
        chk("wd_idle", {stall, mem_rd}, 0);
        chk("wd_saida", saida_cache, held);
        issue_read(12'h033);
        chk("wd_line_unchanged", mem_rd, 1);

        // Reset in the middle of RD_MISS, followed by a late mem_ready.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        respond(32'h7777_7777);
        chk("rst_abort_outs", {stall, mem_rd, mem_wr, mem_err, mem_addr, saida_cache}, 44'h0);
        chk("rst_wdata", mem_wdata, 0);
        issue_read(12'h005);
        chk("rst_invalidated", mem_rd, 1);
        respond(32'h1);
        chk("queues_drained", rd_q.size() + wr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end
endmodule
